// File: rtl/num_scan_drv.sv
// num_scan_drv: multiplexed 8-digit seven-segment scan driver.
// A prescaler steps a digit index through 0..7; one digit is lit per slot.
// New display data is staged in pending registers and only becomes active at
// the end of a full scan, so a frame never shows a mix of old and new data.
// Optional build macro NUM_SCAN_HEX_EN: decode nibbles A-F as hex glyphs
// (A,b,C,d,E,F); without it they show a single dash (segment g).
module num_scan_drv #(
  parameter int unsigned SCAN_DIV = 8000
) (
  input  logic        clk_div8M,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic        blank_en,
  input  logic [7:0]  digit_en,
  output logic [7:0]  num_csn,
  output logic        num_a,
  output logic        num_b,
  output logic        num_c,
  output logic        num_d,
  output logic        num_e,
  output logic        num_f,
  output logic        num_g,
  output logic        num_dp,
  output logic        frame_done,
  output logic        upd_done
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  // Segment vector {a,b,c,d,e,f,g,dp} for one nibble, dp left clear.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hfc;
      4'h1: s = 8'h60;
      4'h2: s = 8'hda;
      4'h3: s = 8'hf2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hb6;
      4'h6: s = 8'hbe;
      4'h7: s = 8'he0;
      4'h8: s = 8'hfe;
      4'h9: s = 8'hf6;
`ifdef NUM_SCAN_HEX_EN
      4'ha: s = 8'hee;
      4'hb: s = 8'h3e;
      4'hc: s = 8'h9c;
      4'hd: s = 8'h7a;
      4'he: s = 8'h9e;
      default: s = 8'h8e;
`else
      default: s = 8'h02;
`endif
    endcase
    return s;
  endfunction

  // Position of the most significant nonzero nibble; 0 when the value is 0,
  // which keeps digit 0 always visible under leading-zero blanking.
  function automatic logic [2:0] top_digit(input logic [31:0] v);
    logic [2:0] t;
    t = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) t = 3'(i);
    end
    return t;
  endfunction

  logic [15:0] div_cnt;
  logic        tick;
  logic        wrap;
  logic [2:0]  idx;

  logic [31:0] pend_val;
  logic [7:0]  pend_dp;
  logic        pend;
  logic [31:0] act_val;
  logic [7:0]  act_dp;

  logic [3:0]  nib_p0;
  logic        blank_p0;
  logic [7:0]  csn_p0;
  logic [7:0]  seg_p0;

  logic [7:0]  csn_p1;
  logic [7:0]  seg_p1;
  logic        frame_p1;
  logic        upd_p1;

  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (idx == 3'd7);

  // Prescaler: counts 0..SCAN_DIV-1, tick on the last count.
  always_ff @(posedge clk_div8M or negedge rstn) begin
    if (!rstn)     div_cnt <= 16'd0;
    else if (tick) div_cnt <= 16'd0;
    else           div_cnt <= div_cnt + 16'd1;
  end

  // Digit index advances once per slot, wrapping 7 -> 0 naturally.
  always_ff @(posedge clk_div8M or negedge rstn) begin
    if (!rstn)     idx <= 3'd0;
    else if (tick) idx <= idx + 3'd1;
  end

  // Pending/active data: transfer only at frame wrap; a coincident load
  // refills pending after the old pending content has moved to active.
  always_ff @(posedge clk_div8M or negedge rstn) begin
    if (!rstn) begin
      pend_val <= 32'd0;
      pend_dp  <= 8'd0;
      pend     <= 1'b0;
      act_val  <= 32'd0;
      act_dp   <= 8'd0;
    end else begin
      if (wrap && pend) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_mask;
        pend     <= 1'b1;
      end else if (wrap) begin
        pend     <= 1'b0;
      end
    end
  end

  // ---- p0: select, decode and blank the current digit ----
  // Builds the select and segment pattern for the digit at idx.
  always_comb begin
    nib_p0   = 4'(act_val >> {idx, 2'b00});
    blank_p0 = blank_en && (idx > top_digit(act_val));
    csn_p0   = 8'hff;
    seg_p0   = 8'h00;
    if (digit_en[idx]) begin
      csn_p0    = ~(8'h01 << idx);
      seg_p0    = blank_p0 ? 8'h00 : seg_decode(nib_p0);
      seg_p0[0] = act_dp[idx];
    end
  end

  // ---- p1: registered outputs ----
  // Output register so selects and segments change on the same edge.
  always_ff @(posedge clk_div8M or negedge rstn) begin
    if (!rstn) begin
      csn_p1   <= 8'hff;
      seg_p1   <= 8'h00;
      frame_p1 <= 1'b0;
      upd_p1   <= 1'b0;
    end else begin
      csn_p1   <= csn_p0;
      seg_p1   <= seg_p0;
      frame_p1 <= wrap;
      upd_p1   <= wrap && pend;
    end
  end

  assign num_csn    = csn_p1;
  assign num_a      = seg_p1[7];
  assign num_b      = seg_p1[6];
  assign num_c      = seg_p1[5];
  assign num_d      = seg_p1[4];
  assign num_e      = seg_p1[3];
  assign num_f      = seg_p1[2];
  assign num_g      = seg_p1[1];
  assign num_dp     = seg_p1[0];
  assign frame_done = frame_p1;
  assign upd_done   = upd_p1;

endmodule

// File: tb/tb_num_scan_drv.sv
// Testbench for num_scan_drv with SCAN_DIV=4: directed scenarios followed by
// random loads/blanking/enables, checked every cycle against a frame-level
// reference model derived from elapsed clock edges.
module tb_num_scan_drv;

  localparam int D = 4;
  localparam int FRAME = 8 * D;

  logic        clk_div8M = 1'b0;
  logic        rstn = 1'b0;
  logic        load = 1'b0;
  logic [31:0] value = 32'd0;
  logic [7:0]  dp_mask = 8'd0;
  logic        blank_en = 1'b0;
  logic [7:0]  digit_en = 8'hff;
  logic [7:0]  num_csn;
  logic        num_a, num_b, num_c, num_d, num_e, num_f, num_g, num_dp;
  logic        frame_done, upd_done;

  num_scan_drv #(.SCAN_DIV(D)) dut (
    .clk_div8M (clk_div8M),
    .rstn      (rstn),
    .load      (load),
    .value     (value),
    .dp_mask   (dp_mask),
    .blank_en  (blank_en),
    .digit_en  (digit_en),
    .num_csn   (num_csn),
    .num_a     (num_a),
    .num_b     (num_b),
    .num_c     (num_c),
    .num_d     (num_d),
    .num_e     (num_e),
    .num_f     (num_f),
    .num_g     (num_g),
    .num_dp    (num_dp),
    .frame_done(frame_done),
    .upd_done  (upd_done)
  );

  always #5 clk_div8M = ~clk_div8M;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Glyph table
  logic [7:0] glyph [16];
  initial begin
    glyph[0] = 8'hfc; glyph[1] = 8'h60; glyph[2] = 8'hda; glyph[3] = 8'hf2;
    glyph[4] = 8'h66; glyph[5] = 8'hb6; glyph[6] = 8'hbe; glyph[7] = 8'he0;
    glyph[8] = 8'hfe; glyph[9] = 8'hf6;
`ifdef NUM_SCAN_HEX_EN
    glyph[10] = 8'hee; glyph[11] = 8'h3e; glyph[12] = 8'h9c;
    glyph[13] = 8'h7a; glyph[14] = 8'h9e; glyph[15] = 8'h8e;
`else
    for (int i = 10; i < 16; i++) glyph[i] = 8'h02;
`endif
  end

  // Reference model state
  int          edges;
  logic [31:0] m_pv, m_act;
  logic [7:0]  m_pdp, m_dpa;
  bit          m_pend;
  logic [7:0]  exp_csn = 8'hff, exp_seg = 8'h00;
  bit          exp_fd = 1'b0, exp_ud = 1'b0;
  int          digit, hi, k, nib;
  logic [7:0]  s;

  // Model: output after edge k shows the slot in effect before edge k;
  // a frame ends on every multiple of FRAME edges since reset release.
  always @(posedge clk_div8M) begin
    if (!rstn) begin
      edges = 0; m_pv = 0; m_act = 0; m_pdp = 0; m_dpa = 0; m_pend = 0;
      exp_csn = 8'hff; exp_seg = 8'h00; exp_fd = 0; exp_ud = 0;
    end else begin
      k = edges + 1;
      digit = (edges / D) % 8;
      hi = 0;
      for (int i = 0; i < 8; i++) if (((m_act >> (4 * i)) & 32'hf) != 0) hi = i;
      nib = int'((m_act >> (4 * digit)) & 32'hf);
      if (!digit_en[digit]) begin
        exp_csn = 8'hff;
        exp_seg = 8'h00;
      end else begin
        exp_csn = ~(8'h01 << digit);
        s = (blank_en && digit > hi) ? 8'h00 : glyph[nib];
        s[0] = m_dpa[digit];
        exp_seg = s;
      end
      exp_fd = (k % FRAME == 0);
      exp_ud = exp_fd && m_pend;
      if (exp_fd && m_pend) begin
        m_act = m_pv; m_dpa = m_pdp; m_pend = 0;
      end
      if (load) begin
        m_pv = value; m_pdp = dp_mask; m_pend = 1;
      end
      edges = k;
    end
  end

  // Per-cycle comparison away from the active edge
  always @(negedge clk_div8M) begin
    if (rstn) begin
      chk_eq("csn", {24'd0, num_csn}, {24'd0, exp_csn});
      chk_eq("seg", {24'd0, num_a, num_b, num_c, num_d, num_e, num_f, num_g, num_dp},
             {24'd0, exp_seg});
      chk_eq("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      chk_eq("upd_done", {31'd0, upd_done}, {31'd0, exp_ud});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_div8M);
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dp);
    load = 1'b1; value = v; dp_mask = dp;
    @(negedge clk_div8M);
    load = 1'b0;
  endtask

  // Wait until the next rising edge is a frame wrap
  task automatic wait_wrap();
    int n;
    n = 0;
    while ((edges % FRAME) != FRAME - 1 && n < 200) begin
      @(negedge clk_div8M);
      n++;
    end
    if (n >= 200) chk_eq("wrap_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_csn"}, {24'd0, num_csn}, 32'h0000_00ff);
    chk_eq({tag, "_seg"}, {24'd0, num_a, num_b, num_c, num_d, num_e, num_f, num_g, num_dp}, 32'd0);
    chk_eq({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    chk_eq({tag, "_ud"}, {31'd0, upd_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] rv;
    cyc(3);
    chk_reset_outputs("rst");
    rstn = 1'b1;
    // free-running scan showing 0
    cyc(70);
    // mid-frame load with blanking
    blank_en = 1'b1;
    cyc(5);
    do_load(32'h0000_1234, 8'h04);
    cyc(80);
    // last load wins within one frame
    cyc(7);
    do_load(32'h1111_1111, 8'h00);
    cyc(3);
    do_load(32'h2222_2222, 8'h00);
    cyc(70);
    // load coincident with the wrap tick while pend=1
    do_load(32'h3333_0000, 8'h80);
    wait_wrap();
    do_load(32'h0000_5678, 8'h01);
    cyc(70);
    // hex nibbles with upper digits disabled
    blank_en = 1'b0;
    digit_en = 8'h0f;
    do_load(32'hABCD_EF00, 8'h00);
    cyc(70);
    digit_en = 8'hff;
    // asynchronous reset with pending data mid-slot
    blank_en = 1'b1;
    do_load(32'h0000_9999, 8'h00);
    cyc(6);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("async_rst");
    cyc(2);
    rstn = 1'b1;
    cyc(70);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) blank_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0)
        digit_en = ($urandom_range(0, 1) == 0) ? 8'hff : 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        rv = $urandom >> (4 * $urandom_range(0, 7));
        load = 1'b1; value = rv; dp_mask = 8'($urandom);
      end else begin
        load = 1'b0;
      end
      @(negedge clk_div8M);
    end
    load = 1'b0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
